// File: rtl/pwm_capture.sv
// Receive-side PWM measurement: synchronises pwm_in, finds edges and reports
// high-time and period once per cycle of the input, or a stuck report on timeout.
module pwm_capture #(
  parameter int WIDTH = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           pwm_in,
  output logic [WIDTH:0] duty,
  output logic [WIDTH:0] period,
  output logic           valid,
  output logic           stuck
);

  localparam logic [WIDTH:0] MAX = {(WIDTH+1){1'b1}};
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

  state_t         state;
  logic           s1, s2, s3;
  logic           rise, fall;
  logic           timeout;
  logic [WIDTH:0] per_cnt, high_cnt;
  logic [WIDTH:0] stuck_duty;

  function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH:0] v, input logic en);
    if (en && (v != MAX)) return v + ONE;
    return v;
  endfunction

  // Stage: input synchroniser and edge detect
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise       = s2 & ~s3;
  assign fall       = ~s2 & s3;
  assign timeout    = (per_cnt == MAX) && !rise;
  assign stuck_duty = s2 ? MAX : '0;

  // Stage: measurement FSM with registered report outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      per_cnt  <= '0;
      high_cnt <= '0;
      duty     <= '0;
      period   <= '0;
      valid    <= 1'b0;
      stuck    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            per_cnt  <= ONE;
            high_cnt <= ONE;
            state    <= HIGH;
          end else if (timeout) begin
            duty   <= stuck_duty;
            period <= '0;
            stuck  <= 1'b1;
            valid  <= 1'b1;
            state  <= STUCK;
          end else begin
            per_cnt <= sat_inc(per_cnt, 1'b1);
          end
        end
        HIGH: begin
          // The timeout wins over a simultaneous fall so the counter never wraps.
          if (timeout) begin
            duty   <= stuck_duty;
            period <= '0;
            stuck  <= 1'b1;
            valid  <= 1'b1;
            state  <= STUCK;
          end else begin
            per_cnt  <= sat_inc(per_cnt, 1'b1);
            high_cnt <= sat_inc(high_cnt, s2);
            if (fall) state <= LOW;
          end
        end
        LOW: begin
          if (rise) begin
            duty     <= high_cnt;
            period   <= per_cnt;
            stuck    <= 1'b0;
            valid    <= 1'b1;
            per_cnt  <= ONE;
            high_cnt <= ONE;
            state    <= HIGH;
          end else if (timeout) begin
            duty   <= stuck_duty;
            period <= '0;
            stuck  <= 1'b1;
            valid  <= 1'b1;
            state  <= STUCK;
          end else begin
            per_cnt <= sat_inc(per_cnt, 1'b1);
          end
        end
        STUCK: begin
          if (rise) begin
            per_cnt  <= ONE;
            high_cnt <= ONE;
            state    <= HIGH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports, once per period, the number of clock cycles it was high and the total period length in clock cycles. It is the receive-side counterpart to the PWM generator built on the free-running 8-bit timebase, and is used to check and decode PWM outputs within the MIPS system. The block synchronises the asynchronous input, detects edges, and measures with saturating counters. It detects a stuck (non-toggling) input by timeout.

## Interface
Parameters:
- WIDTH, default 8: timebase width of the source generator. Measurement counters and outputs are WIDTH+1 bits, so a full 2^WIDTH-cycle period is representable.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; sampled on posedge clock.
- pwm_in  input  1  asynchronous PWM input.
- duty  output  WIDTH+1  high-cycle count of the last complete period.
- period  output  WIDTH+1  total cycle count of the last complete period.
- valid  output  1  one-cycle pulse: duty/period/stuck were updated this cycle.
- stuck  output  1  last report was a timeout, not a measured period.

## Operation
- Synchroniser: s1 <= pwm_in; s2 <= s1; s3 <= s2. All three reset to 0.
- rise = s2 & ~s3; fall = ~s2 & s3. These signals are combinational and are consumed by the FSM on the next posedge.
- Counters: per_cnt and high_cnt, each WIDTH+1 bits. MAX = 2^(WIDTH+1)-1, which is 511 for the default.
- FSM states: IDLE, HIGH, LOW, STUCK. Reset state is IDLE.
- IDLE:
  - On rise: per_cnt <= 1, high_cnt <= 1, go to HIGH. This partial period produces no report.
  - Otherwise: per_cnt <= per_cnt+1.
  - Timeout (per_cnt == MAX and no rise): report stuck, go to STUCK.
- HIGH:
  - Every cycle: per_cnt++, high_cnt += s2.
  - On fall: go to LOW.
  - Timeout (per_cnt == MAX): report stuck, go to STUCK.
- LOW:
  - On rise: duty <= high_cnt, period <= per_cnt, valid <= 1, stuck <= 0. Then per_cnt <= 1, high_cnt <= 1, go to HIGH.
  - Otherwise: per_cnt++.
  - Timeout (per_cnt == MAX and no rise): report stuck, go to STUCK.
- Stuck report:
  - duty <= s2 ? MAX : 0; period <= 0; stuck <= 1; valid <= 1.
  - Exactly one report per stuck episode.
- STUCK: counters hold. On rise: per_cnt <= 1, high_cnt <= 1, go to HIGH. The first period after STUCK is reported normally; stuck clears with that report.
- Counters never wrap. A timeout is taken before increment past MAX.
- Rise and fall cannot coincide, since s2 toggles at most once per cycle.
- A rise in HIGH is impossible, because fall must precede it.

## Timing
- Reset values: duty=0, period=0, valid=0, stuck=0, state=IDLE, counters=0, s1/s2/s3=0.
- Latency: pwm_in first sampled high at posedge k. s2=1 after k+1, and rise is seen at posedge k+2. valid is high in the cycle following posedge k+2 (k+2 to k+3).
- duty and period are registered and hold until the next report. valid is never high for two consecutive cycles.
- Measurement is exact for a waveform stable across each sample. For input high H cycles and low L cycles, the report is duty=H, period=H+L. This holds provided H+L <= MAX.
- Reset asserted mid-measurement clears everything on that posedge; no report is emitted.
- pwm_in high at reset release produces a rise two cycles later. This only starts a measurement, with no report.

## Test plan
- Generator with WIDTH=8, period 256, compare 64 (high 64 / low 192) -> from the second rise onward, valid every 256 cycles with duty=64, period=256, stuck=0.
- Duty 1 (high 1, low 255) and duty 255 (high 255, low 1) -> duty=1/period=256, and duty=255/period=256 respectively.
- pwm_in held 0 from reset -> single valid at per_cnt=511 with duty=0, period=0, stuck=1; no further valid.
- Running 64/192 waveform, then pwm_in forced high -> one report with duty=511, period=0, stuck=1. Restoring the waveform -> first full period reported as duty=64, period=256, stuck=0.
- Reset asserted mid-HIGH -> all outputs 0 the next cycle. On release, the first period after reset produces no valid; the following period reports correctly.
- Back-to-back short periods (high 2, low 3) -> valid every 5 cycles with duty=2, period=5, never asserted in adjacent cycles.
